// File: rtl/jtkunio_pkg.sv
// Shared definitions for the Kunio video pipeline: palette index bases,
// gfx_en layer bit positions and the packed RGB pixel type.
package jtkunio_pkg;

  localparam logic [7:0] IDX_CHAR_BASE = 8'h00;
  localparam logic [7:0] IDX_SCR_BASE  = 8'h40;
  localparam logic [7:0] IDX_OBJ_BASE  = 8'h80;

  localparam int GFX_CHAR = 0;
  localparam int GFX_SCR  = 1;
  localparam int GFX_OBJ  = 3;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } rgb_t;

  // A layer pixel only wins priority when enabled and its colour is not 0.
  function automatic logic opaque(input logic [2:0] col, input logic en);
    return en && (col != 3'd0);
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Byte-wide dual-port RAM: port 0 read/write, port 1 read-only, both with
// registered outputs. Read-during-write on port 0 returns the old data.
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk0,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic          clk1,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk0) begin
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
  end

  always_ff @(posedge clk1) begin
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtkunio_prio.sv
// Layer priority mux: char over obj over scroll, scroll used as-is when
// every layer is transparent. Produces the 8-bit palette index.
module jtkunio_prio
  import jtkunio_pkg::*;
(
  input  logic [5:0] scr_pxl,
  input  logic [5:0] char_pxl,
  input  logic [6:0] obj_pxl,
  input  logic [3:0] gfx_en,
  output logic [7:0] pal_addr
);

  // Scroll is the fallback, so its enable bit never changes the index.
  logic unused_gfx;
  assign unused_gfx = &{1'b0, gfx_en[GFX_SCR], gfx_en[2]};

  always_comb begin
    pal_addr = IDX_SCR_BASE | {2'b00, scr_pxl};
    if (opaque(char_pxl[2:0], gfx_en[GFX_CHAR]))
      pal_addr = IDX_CHAR_BASE | {2'b00, char_pxl};
    else if (opaque(obj_pxl[2:0], gfx_en[GFX_OBJ]))
      pal_addr = IDX_OBJ_BASE | {1'b0, obj_pxl};
  end

endmodule

// File: rtl/jtkunio_colmix.sv
// Kunio colour mixer: priority mux, CPU-writable 256x12 palette and a
// three-tick pixel pipeline with blanking delayed to match.
module jtkunio_colmix
  import jtkunio_pkg::*;
#(
  parameter int BLANK_DLY = 3
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [5:0] scr_pxl,
  input  logic [5:0] char_pxl,
  input  logic [6:0] obj_pxl,
  input  logic [8:0] cpu_addr,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  input  logic [3:0] gfx_en,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic [7:0]           prio_idx;
  logic [7:0]           pal_addr_p0_q;
  rgb_t                 pal_rgb_p1_q;
  rgb_t                 rgb_p2_q, rgb_p2_d;
  logic [BLANK_DLY-1:0] hbl_q, vbl_q;
  logic [7:0]           lo_cpu, hi_cpu, lo_vid, hi_vid;
  logic                 cpu_we, sel_hi_q, rd_ok_q;
  logic                 unused_hi;

  assign cpu_we    = pal_cs & ~cpu_wrn;
  assign unused_hi = &{1'b0, hi_vid[7:4]};

  jtkunio_prio u_prio (
    .scr_pxl  (scr_pxl),
    .char_pxl (char_pxl),
    .obj_pxl  (obj_pxl),
    .gfx_en   (gfx_en),
    .pal_addr (prio_idx)
  );

  jtframe_dual_ram #(.DW(8), .AW(8)) u_ram_lo (
    .clk0  (clk),
    .data0 (cpu_dout),
    .addr0 (cpu_addr[7:0]),
    .we0   (cpu_we & ~cpu_addr[8]),
    .q0    (lo_cpu),
    .clk1  (clk),
    .addr1 (pal_addr_p0_q),
    .q1    (lo_vid)
  );

  jtframe_dual_ram #(.DW(8), .AW(8)) u_ram_hi (
    .clk0  (clk),
    .data0 (cpu_dout),
    .addr0 (cpu_addr[7:0]),
    .we0   (cpu_we & cpu_addr[8]),
    .q0    (hi_cpu),
    .clk1  (clk),
    .addr1 (pal_addr_p0_q),
    .q1    (hi_vid)
  );

  // Blank status of the pixel now in pal_rgb sits one stage before the output.
  assign rgb_p2_d = (hbl_q[BLANK_DLY-2] & vbl_q[BLANK_DLY-2]) ? pal_rgb_p1_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_addr_p0_q <= '0;
      pal_rgb_p1_q  <= '0;
      rgb_p2_q      <= '0;
      hbl_q         <= '0;
      vbl_q         <= '0;
    end else if (pxl_cen) begin
      // Tick 0: priority index
      pal_addr_p0_q <= prio_idx;
      // Tick 1: palette colour {B, G, R}
      pal_rgb_p1_q  <= {hi_vid[3:0], lo_vid};
      // Tick 2: blanked output
      rgb_p2_q      <= rgb_p2_d;
      hbl_q         <= {hbl_q[BLANK_DLY-2:0], LHBL};
      vbl_q         <= {vbl_q[BLANK_DLY-2:0], LVBL};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_hi_q <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      sel_hi_q <= cpu_addr[8];
      rd_ok_q  <= 1'b1;
    end
  end

  assign cpu_din  = rd_ok_q ? (sel_hi_q ? hi_cpu : lo_cpu) : 8'd0;
  assign red      = rgb_p2_q.r;
  assign green    = rgb_p2_q.g;
  assign blue     = rgb_p2_q.b;
  assign LHBL_dly = hbl_q[BLANK_DLY-1];
  assign LVBL_dly = vbl_q[BLANK_DLY-1];

endmodule
